// File: rtl/ber_pkg.sv
// Shared definitions for the PRBS9 bit-error-rate checker and its reference generator.
package ber_pkg;

    // PRBS9 polynomial x^9 + x^5 + 1
    localparam int PRBS_LEN = 9;
    localparam int PRBS_TAP = 5;
    localparam logic [PRBS_LEN-1:0] PRBS_SEED_DEFAULT = 9'h1AA;

    // Candidate delay spans one full PRBS9 period plus the zero-delay tap
    localparam int DELAY_W  = 9;
    localparam int HIST_LEN = 511;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } ber_state_t;

    // One Fibonacci step: shift left, feed back out[t] ^ out[t+4]
    function automatic logic [PRBS_LEN-1:0] prbs9_step(input logic [PRBS_LEN-1:0] s);
        return {s[PRBS_LEN-2:0], s[PRBS_LEN-1] ^ s[PRBS_TAP-1]};
    endfunction

endpackage

// File: rtl/prbs9_gen.sv
// PRBS9 Fibonacci generator; the output bit is the MSB of the current state,
// so the first PRBS_LEN outputs after reset are the seed, MSB first.
module prbs9_gen
    import ber_pkg::*;
#(
    parameter logic [PRBS_LEN-1:0] SEED = PRBS_SEED_DEFAULT
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_bit
);

    logic [PRBS_LEN-1:0] lfsr_q;
    logic [PRBS_LEN-1:0] lfsr_d;

    // Advance one step per enable, otherwise hold
    always_comb begin
        lfsr_d = lfsr_q;
        if (i_enable) begin
            lfsr_d = prbs9_step(lfsr_q);
        end
    end

    // State register with synchronous reload of the seed
    always_ff @(posedge clock) begin
        if (i_reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_bit = lfsr_q[PRBS_LEN-1];

endmodule

// File: rtl/ber_checker_qi_rx.sv
// Receive-side BER checker: decimates the oversampled filter output, slices
// the sign, aligns a local PRBS9 by sweeping delay, then counts bits/errors.
module ber_checker_qi_rx
    import ber_pkg::*;
#(
    parameter int                  NB_INPUT      = 8,
    parameter logic [PRBS_LEN-1:0] SEED          = PRBS_SEED_DEFAULT,
    parameter int                  WINDOW        = 511,
    parameter int                  LOCK_THRESH   = 0,
    parameter int                  UNLOCK_THRESH = 128,
    parameter int                  NB_COUNT      = 64
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [1:0]          i_counterMux,
    input  logic [1:0]          i_phase,
    input  logic                i_clear,
    input  logic [NB_INPUT-1:0] i_sample,
    output logic                o_locked,
    output logic [DELAY_W-1:0]  o_delay,
    output logic [NB_COUNT-1:0] o_bit_count,
    output logic [NB_COUNT-1:0] o_err_count
);

    localparam int NB_WIN = $clog2(WINDOW + 1);

    logic                stb;
    logic                rx_bit;
    logic                ref_now;
    logic                mismatch;
    logic                win_end;
    logic [31:0]         win_total;
    logic [HIST_LEN:0]   cmp_vec;
    logic                unused_sample;

    ber_state_t          state_q, state_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic [HIST_LEN-1:0] hist_q, hist_d;
    logic [NB_WIN-1:0]   win_cnt_q, win_cnt_d;
    logic [NB_WIN-1:0]   win_err_q, win_err_d;
    logic [NB_COUNT-1:0] bit_cnt_q, bit_cnt_d;
    logic [NB_COUNT-1:0] err_cnt_q, err_cnt_d;

    assign stb    = i_enable && (i_counterMux == i_phase);
    // Transmit maps 0 -> +coef, 1 -> -coef, so the sign bit is the data bit
    assign rx_bit = i_sample[NB_INPUT-1];
    assign unused_sample = ^i_sample[NB_INPUT-2:0];

    prbs9_gen #(
        .SEED(SEED)
    ) u_ref (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (stb),
        .o_bit    (ref_now)
    );

    // Tap 0 is the current reference bit, tap K is the bit from K strobes ago
    assign cmp_vec   = {hist_q, ref_now};
    assign mismatch  = rx_bit ^ cmp_vec[delay_q];
    assign win_end   = (win_cnt_q == NB_WIN'(WINDOW - 1));
    assign win_total = 32'(win_err_q) + 32'(mismatch);

    // Alignment FSM, reference history and per-window error accounting
    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        hist_d    = hist_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        if (stb) begin
            hist_d = {hist_q[HIST_LEN-2:0], ref_now};
            if (win_end) begin
                win_cnt_d = '0;
                win_err_d = '0;
                if (state_q == SEARCH) begin
                    if (win_total <= 32'(LOCK_THRESH)) begin
                        state_d = LOCKED;
                    end else begin
                        delay_d = delay_q + 1'b1;
                    end
                end else if (win_total > 32'(UNLOCK_THRESH)) begin
                    state_d = SEARCH;
                    delay_d = delay_q + 1'b1;
                end
            end else begin
                win_cnt_d = win_cnt_q + 1'b1;
                win_err_d = win_err_q + NB_WIN'(mismatch);
            end
        end
    end

    // Saturating bit/error counters; clear overrides any same-cycle increment
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        if (stb && (state_q == LOCKED)) begin
            if (bit_cnt_q != '1) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            if (mismatch && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
        if (i_clear) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    // State registers
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q   <= SEARCH;
            delay_q   <= '0;
            hist_q    <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            hist_q    <= hist_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_locked    = (state_q == LOCKED);
    assign o_delay     = delay_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_ber_checker_qi_rx.sv
// Bench for ber_checker_qi_rx: two instances (default-like window, and a short
// window with 4-bit counters) checked every cycle against a sequence-level model.
module tb_ber_checker_qi_rx;

    localparam int K = 37;

    logic       clock = 1'b0;
    logic       i_reset, i_enable, i_clear;
    logic [1:0] i_counterMux, i_phase;
    logic [7:0] i_sample;

    logic        a_locked, b_locked;
    logic [8:0]  a_delay, b_delay;
    logic [15:0] a_bits, a_errs;
    logic [3:0]  b_bits, b_errs;

    always #5 clock = ~clock;

    ber_checker_qi_rx #(
        .NB_COUNT(16)
    ) dut_a (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_counterMux (i_counterMux),
        .i_phase      (i_phase),
        .i_clear      (i_clear),
        .i_sample     (i_sample),
        .o_locked     (a_locked),
        .o_delay      (a_delay),
        .o_bit_count  (a_bits),
        .o_err_count  (a_errs)
    );

    ber_checker_qi_rx #(
        .WINDOW        (15),
        .UNLOCK_THRESH (4),
        .NB_COUNT      (4)
    ) dut_b (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_counterMux (i_counterMux),
        .i_phase      (i_phase),
        .i_clear      (i_clear),
        .i_sample     (i_sample),
        .o_locked     (b_locked),
        .o_delay      (b_delay),
        .o_bit_count  (b_bits),
        .o_err_count  (b_errs)
    );

    int checks   = 0;
    int failures = 0;

    // PRBS9(1AA) sequence: first 9 bits are the seed MSB-first, then
    // out(i) = out(i-9) ^ out(i-5) for x^9 + x^5 + 1
    bit prbs_tab [0:510];

    function automatic bit ref_bit(input int k);
        return prbs_tab[k % 511];
    endfunction

    // Model state, one slot per instance
    int     win_p [2] = '{511, 15};
    int     lt_p  [2] = '{0, 0};
    int     ut_p  [2] = '{128, 4};
    longint max_p [2] = '{65535, 15};
    bit     m_locked [2];
    int     m_delay [2];
    int     m_wcnt [2];
    int     m_werr [2];
    int     m_n [2];
    longint m_bits [2];
    longint m_errs [2];

    bit cmp_on    = 1'b0;
    bit b_wrapped = 1'b0;
    int b_prev_delay = 0;

    // Sequence-level model: reference bit k strobes back is prbs[(n-k) mod 511]
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (i_reset) begin
                m_locked[i] = 1'b0;
                m_delay[i]  = 0;
                m_wcnt[i]   = 0;
                m_werr[i]   = 0;
                m_n[i]      = 0;
                m_bits[i]   = 0;
                m_errs[i]   = 0;
            end else begin
                if (i_enable && (i_counterMux == i_phase)) begin
                    bit rx, cb, mm;
                    int total;
                    rx = ($signed(i_sample) < 0);
                    cb = (m_n[i] - m_delay[i] >= 0) ? ref_bit(m_n[i] - m_delay[i]) : 1'b0;
                    mm = rx ^ cb;
                    if (m_locked[i]) begin
                        if (m_bits[i] < max_p[i]) m_bits[i] = m_bits[i] + 1;
                        if (mm && (m_errs[i] < max_p[i])) m_errs[i] = m_errs[i] + 1;
                    end
                    if (m_wcnt[i] == win_p[i] - 1) begin
                        total = m_werr[i] + int'(mm);
                        if (!m_locked[i]) begin
                            if (total <= lt_p[i]) m_locked[i] = 1'b1;
                            else m_delay[i] = (m_delay[i] + 1) % 512;
                        end else if (total > ut_p[i]) begin
                            m_locked[i] = 1'b0;
                            m_delay[i]  = (m_delay[i] + 1) % 512;
                        end
                        m_wcnt[i] = 0;
                        m_werr[i] = 0;
                    end else begin
                        m_wcnt[i] = m_wcnt[i] + 1;
                        m_werr[i] = m_werr[i] + int'(mm);
                    end
                    m_n[i] = m_n[i] + 1;
                end
                if (i_clear) begin
                    m_bits[i] = 0;
                    m_errs[i] = 0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clock) begin
        if (cmp_on) begin
            checks++;
            if (a_locked !== m_locked[0] || a_delay !== 9'(m_delay[0]) ||
                a_bits !== 16'(m_bits[0]) || a_errs !== 16'(m_errs[0])) begin
                failures++;
                $display("FAIL model_A t=%0t got lk=%0b dly=%0d bits=%0d errs=%0d required lk=%0b dly=%0d bits=%0d errs=%0d",
                         $time, a_locked, a_delay, a_bits, a_errs,
                         m_locked[0], m_delay[0], m_bits[0], m_errs[0]);
            end
            checks++;
            if (b_locked !== m_locked[1] || b_delay !== 9'(m_delay[1]) ||
                b_bits !== 4'(m_bits[1]) || b_errs !== 4'(m_errs[1])) begin
                failures++;
                $display("FAIL model_B t=%0t got lk=%0b dly=%0d bits=%0d errs=%0d required lk=%0b dly=%0d bits=%0d errs=%0d",
                         $time, b_locked, b_delay, b_bits, b_errs,
                         m_locked[1], m_delay[1], m_bits[1], m_errs[1]);
            end
            if (b_prev_delay == 511 && b_delay == 9'd0) b_wrapped = 1'b1;
            b_prev_delay = int'(b_delay);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Transmit side: symbol index since reset, stream delayed by K symbols
    bit inv  = 1'b0;
    int tx_n = 0;

    function automatic bit tx_bit();
        bit b;
        b = (tx_n >= K) ? ref_bit(tx_n - K) : 1'b0;
        return b ^ inv;
    endfunction

    function automatic logic [7:0] enc(input bit b);
        return b ? 8'hC0 : 8'h40;
    endfunction

    // One symbol: fixed mode is one cycle at counterMux 2; phase mode sweeps
    // counterMux 0..3 with valid data at 2 and the complement elsewhere
    task automatic sym(input bit phase_mode, input bit flip, input bit clr);
        bit b;
        b = tx_bit() ^ flip;
        if (!phase_mode) begin
            @(posedge clock); #1;
            i_enable     = 1'b1;
            i_counterMux = 2'd2;
            i_clear      = clr;
            i_sample     = enc(b);
        end else begin
            for (int c = 0; c < 4; c++) begin
                @(posedge clock); #1;
                i_enable     = 1'b1;
                i_counterMux = 2'(c);
                i_clear      = 1'b0;
                i_sample     = (c == 2) ? enc(b) : enc(~b);
            end
        end
        tx_n++;
    endtask

    task automatic pause();
        @(posedge clock); #1;
        i_enable = 1'b0;
        i_clear  = 1'b0;
        @(negedge clock); #1;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_clear  = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        i_reset = 1'b0;
        tx_n    = 0;
        @(negedge clock); #1;
    endtask

    initial begin
        logic [9:0] head;
        i_reset      = 1'b1;
        i_enable     = 1'b0;
        i_clear      = 1'b0;
        i_counterMux = 2'd0;
        i_phase      = 2'd2;
        i_sample     = 8'h00;

        for (int i = 0; i < 9; i++) prbs_tab[i] = (9'h1AA >> (8 - i)) & 1;
        for (int i = 9; i < 511; i++) prbs_tab[i] = prbs_tab[i-9] ^ prbs_tab[i-5];
        for (int i = 0; i < 10; i++) head[9-i] = prbs_tab[i];
        chk("prbs_model_head", 64'(head), 64'(10'b1101010101));

        @(posedge clock);
        @(posedge clock); #1;
        cmp_on  = 1'b1;
        i_reset = 1'b0;
        @(negedge clock); #1;
        chk("reset_A_locked", 64'(a_locked), 0);
        chk("reset_A_delay",  64'(a_delay), 0);
        chk("reset_A_bits",   64'(a_bits), 0);
        chk("reset_A_errs",   64'(a_errs), 0);
        chk("reset_B_delay",  64'(b_delay), 0);

        // Wrong phase sees only complemented samples: no lock
        i_phase = 2'd0;
        repeat (300) sym(1'b1, 1'b0, 1'b0);
        pause();
        chk("phase0_B_locked", 64'(b_locked), 0);
        chk("phase0_B_delay",  64'(b_delay), 20);
        i_phase = 2'd2;
        repeat (269) sym(1'b1, 1'b0, 1'b0);
        pause();
        chk("phase2_B_prelock", 64'(b_locked), 0);
        chk("phase2_B_delay",   64'(b_delay), 37);
        sym(1'b1, 1'b0, 1'b0);
        pause();
        chk("phase2_B_locked", 64'(b_locked), 1);

        // Reset while B is locked, then full-window lock of A
        do_reset();
        chk("rst_B_locked", 64'(b_locked), 0);
        chk("rst_B_delay",  64'(b_delay), 0);
        chk("rst_B_bits",   64'(b_bits), 0);
        repeat (19417) sym(1'b0, 1'b0, 1'b0);
        pause();
        chk("lock_A_pre",       64'(a_locked), 0);
        chk("lock_A_pre_delay", 64'(a_delay), 37);
        sym(1'b0, 1'b0, 1'b0);
        pause();
        chk("lock_A_locked", 64'(a_locked), 1);
        chk("lock_A_delay",  64'(a_delay), 37);
        chk("lock_A_bits",   64'(a_bits), 0);
        chk("lock_A_errs",   64'(a_errs), 0);
        chk("lock_B_bits_sat", 64'(b_bits), 15);

        // One flipped bit every 100 strobes
        for (int j = 0; j < 10000; j++) sym(1'b0, (j % 100) == 0, 1'b0);
        pause();
        chk("err_A_errs",   64'(a_errs), 100);
        chk("err_A_bits",   64'(a_bits), 10000);
        chk("err_A_locked", 64'(a_locked), 1);
        chk("err_B_errs_sat", 64'(b_errs), 15);
        chk("err_B_locked", 64'(b_locked), 1);

        // Clear on a locked strobe wins over the increment
        sym(1'b0, 1'b0, 1'b1);
        pause();
        chk("clr_A_bits", 64'(a_bits), 0);
        chk("clr_A_errs", 64'(a_errs), 0);
        chk("clr_B_bits", 64'(b_bits), 0);
        sym(1'b0, 1'b1, 1'b0);
        pause();
        chk("post_clr_A_bits", 64'(a_bits), 1);
        chk("post_clr_A_errs", 64'(a_errs), 1);

        // Reset mid-lock and relock at the same delay
        do_reset();
        chk("rst_A_locked", 64'(a_locked), 0);
        chk("rst_A_delay",  64'(a_delay), 0);
        chk("rst_A_bits",   64'(a_bits), 0);
        chk("rst_A_errs",   64'(a_errs), 0);
        repeat (19418) sym(1'b0, 1'b0, 1'b0);
        pause();
        chk("relock_A_locked", 64'(a_locked), 1);
        chk("relock_A_delay",  64'(a_delay), 37);

        // Inverted stream: lock drops after one window, counters hold
        inv = 1'b1;
        repeat (511) sym(1'b0, 1'b0, 1'b0);
        pause();
        chk("loss_A_locked", 64'(a_locked), 0);
        chk("loss_A_delay",  64'(a_delay), 38);
        chk("loss_A_bits",   64'(a_bits), 511);
        chk("loss_A_errs",   64'(a_errs), 511);
        chk("loss_B_locked", 64'(b_locked), 0);
        repeat (7680) sym(1'b0, 1'b0, 1'b0);
        pause();
        chk("inv_A_bits_hold", 64'(a_bits), 511);
        chk("inv_A_locked",    64'(a_locked), 0);
        chk("inv_B_locked",    64'(b_locked), 0);
        chk("inv_B_wrapped",   64'(b_wrapped), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
